// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the USB receive controller.
// Holds the controller state enum, the SYNC pattern, the per-packet data
// byte limit and a PID integrity helper. The helper is only called when
// USB_RX_PID_CHECK_EN is defined.
package usb_rx_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned PID_W     = 4;
    localparam int unsigned COUNT_W   = 7;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [BYTE_W-1:0]  SYNC_BYTE = 8'h80;
    localparam logic [COUNT_W-1:0] MAX_BYTES = 7'd66;

    typedef enum logic [3:0] {
        IDLE,
        RECV_SYNC,
        CHK_SYNC,
        RECV_PID,
        CHK_PID,
        RECV_DATA,
        WRITE,
        EOP_WAIT,
        ERR_EOP,
        ERR_IDLE
    } rx_state_t;

    // A PID byte carries its 4-bit code in [3:0] and the one's complement in [7:4]
    function automatic logic pid_is_valid(input logic [BYTE_W-1:0] pid_byte);
        return pid_byte[BYTE_W-1:PID_W] == ~pid_byte[PID_W-1:0];
    endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: counts sampled bits within the current byte.
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   clear         hold the count (and byte_done) at zero
//   count_enable  bit-sample strobe
//   bit_count     bits of the current byte already sampled
//   byte_done     high for the cycle after the eighth strobe of a byte
module rx_bit_counter
    import usb_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 count_enable,
    output logic [BIT_CNT_W-1:0] bit_count,
    output logic                 byte_done
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = '1;

    // Wrapping bit counter; byte_done flags the 7->0 wrap one cycle later
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_count <= '0;
            byte_done <= 1'b0;
        end else if (clear) begin
            bit_count <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= count_enable && (bit_count == LAST_BIT);
            if (count_enable) begin
                bit_count <= bit_count + BIT_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: USB packet receive controller.
// Tracks SYNC, PID and data bytes from the decoder/shift register, strobes
// completed data bytes into the RX FIFO and flags receive errors.
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   d_edge        line transition pulse
//   eop           end-of-packet line state (qualified by shift_enable)
//   shift_enable  bit-sample strobe
//   rcv_data      assembled byte, valid the cycle after byte_done
//   rcving        packet in progress
//   w_enable      FIFO write strobe
//   r_error       sticky receive error
//   rx_pid        PID of the current packet, pid_valid strobes on load
//   rx_done       error-free packet completion strobe
//   byte_count    data bytes written in the current packet
// Build option: define USB_RX_PID_CHECK_EN to reject PIDs whose upper
// nibble is not the complement of the lower nibble.
module usb_rx_ctrl
    import usb_rx_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               d_edge,
    input  logic               eop,
    input  logic               shift_enable,
    input  logic [BYTE_W-1:0]  rcv_data,
    output logic               rcving,
    output logic               w_enable,
    output logic               r_error,
    output logic [PID_W-1:0]   rx_pid,
    output logic               pid_valid,
    output logic               rx_done,
    output logic [COUNT_W-1:0] byte_count
);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [BIT_CNT_W-1:0] bit_count;
    logic                 byte_done;
    logic                 cnt_clear;
    logic                 sampled_eop;

    logic                 rcving_next;
    logic                 w_enable_next;
    logic                 r_error_next;
    logic [PID_W-1:0]     rx_pid_next;
    logic                 pid_valid_next;
    logic                 rx_done_next;
    logic [COUNT_W-1:0]   byte_count_next;

    // Bits are only counted while a byte is being shifted in
    assign cnt_clear   = !((state == RECV_SYNC) || (state == RECV_PID) || (state == RECV_DATA));
    assign sampled_eop = shift_enable && eop;

    rx_bit_counter u_bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (shift_enable),
        .bit_count    (bit_count),
        .byte_done    (byte_done)
    );

    // State register and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            rcving     <= 1'b0;
            w_enable   <= 1'b0;
            r_error    <= 1'b0;
            rx_pid     <= '0;
            pid_valid  <= 1'b0;
            rx_done    <= 1'b0;
            byte_count <= '0;
        end else begin
            state      <= state_next;
            rcving     <= rcving_next;
            w_enable   <= w_enable_next;
            r_error    <= r_error_next;
            rx_pid     <= rx_pid_next;
            pid_valid  <= pid_valid_next;
            rx_done    <= rx_done_next;
            byte_count <= byte_count_next;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_next      = state;
        w_enable_next   = 1'b0;
        pid_valid_next  = 1'b0;
        rx_done_next    = 1'b0;
        r_error_next    = r_error;
        rx_pid_next     = rx_pid;
        byte_count_next = byte_count;

        case (state)
            IDLE, ERR_IDLE: begin
                if (d_edge) begin
                    state_next      = RECV_SYNC;
                    r_error_next    = 1'b0;
                    byte_count_next = '0;
                end
            end
            RECV_SYNC, RECV_PID: begin
                // byte_done outranks a coincident EOP sample
                if (byte_done) begin
                    state_next = (state == RECV_SYNC) ? CHK_SYNC : CHK_PID;
                end else if (sampled_eop) begin
                    r_error_next = 1'b1;
                    state_next   = ERR_IDLE;
                end
            end
            CHK_SYNC: begin
                if (rcv_data == SYNC_BYTE) begin
                    state_next = RECV_PID;
                end else begin
                    r_error_next = 1'b1;
                    state_next   = ERR_EOP;
                end
            end
            CHK_PID: begin
`ifdef USB_RX_PID_CHECK_EN
                if (pid_is_valid(rcv_data)) begin
                    rx_pid_next    = rcv_data[PID_W-1:0];
                    pid_valid_next = 1'b1;
                    state_next     = RECV_DATA;
                end else begin
                    r_error_next = 1'b1;
                    state_next   = ERR_EOP;
                end
`else
                rx_pid_next    = rcv_data[PID_W-1:0];
                pid_valid_next = 1'b1;
                state_next     = RECV_DATA;
`endif
            end
            RECV_DATA: begin
                // EOP is only legal on a byte boundary
                if (byte_done) begin
                    state_next = WRITE;
                end else if (sampled_eop) begin
                    if (bit_count == '0) begin
                        state_next = EOP_WAIT;
                    end else begin
                        r_error_next = 1'b1;
                        state_next   = ERR_IDLE;
                    end
                end
            end
            WRITE: begin
                if (byte_count == MAX_BYTES) begin
                    r_error_next = 1'b1;
                    state_next   = ERR_EOP;
                end else begin
                    w_enable_next   = 1'b1;
                    byte_count_next = byte_count + COUNT_W'(1);
                    state_next      = RECV_DATA;
                end
            end
            EOP_WAIT: begin
                if (d_edge) begin
                    rx_done_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            ERR_EOP: begin
                if (sampled_eop) begin
                    state_next = ERR_IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        rcving_next = !((state_next == IDLE) || (state_next == ERR_IDLE));
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: self-checking bench for usb_rx_ctrl.
// Drives whole packets (SYNC, PID, data, optional truncation, EOP) and
// compares strobe counts and final outputs against a packet-level model.
module tb_usb_rx_ctrl;

    logic       clk;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [3:0] rx_pid;
    logic       pid_valid;
    logic       rx_done;
    logic [6:0] byte_count;

    int err_cnt  = 0;
    int chk_cnt  = 0;
    int w_cnt    = 0;
    int pv_cnt   = 0;
    int done_cnt = 0;
    int clash_cnt = 0;
    int exp_pid  = 0;

`ifdef USB_RX_PID_CHECK_EN
    localparam bit PID_CHECK = 1'b1;
`else
    localparam bit PID_CHECK = 1'b0;
`endif

    usb_rx_ctrl dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .eop          (eop),
        .shift_enable (shift_enable),
        .rcv_data     (rcv_data),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error),
        .rx_pid       (rx_pid),
        .pid_valid    (pid_valid),
        .rx_done      (rx_done),
        .byte_count   (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (w_enable)  w_cnt++;
        if (pid_valid) pv_cnt++;
        if (rx_done)   done_cnt++;
        if (w_enable && rx_done) clash_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_edge();
        tick();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    // One bit-sample strobe after a random idle gap (strobes >= 4 cycles apart)
    task automatic shift_bit();
        repeat ($urandom_range(3, 7)) tick();
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) shift_bit();
        rcv_data = b;
    endtask

    // Packet-level expectation from the protocol rules
    task automatic model_packet(input logic [7:0] s, input logic [7:0] p,
                                input int n, input int trunc,
                                output int ew, output int epv, output int ed,
                                output int eerr, output int ebc);
        int hi;
        int lo;
        ew = 0; epv = 0; ed = 0; eerr = 0; ebc = 0;
        hi = int'(p) / 16;
        lo = int'(p) % 16;
        if (s != 8'h80) begin
            eerr = 1;
        end else if (PID_CHECK && (hi + lo != 15)) begin
            eerr = 1;
        end else begin
            epv = 1;
            exp_pid = lo;
            if (n > 66) begin
                ew = 66; ebc = 66; eerr = 1;
            end else begin
                ew = n; ebc = n;
                if (trunc > 0) eerr = 1;
                else           ed = 1;
            end
        end
    endtask

    task automatic run_packet(input logic [7:0] s, input logic [7:0] p,
                              input int n, input int trunc);
        int ew, epv, ed, eerr, ebc;
        int w0, pv0, d0, c0;
        model_packet(s, p, n, trunc, ew, epv, ed, eerr, ebc);
        w0 = w_cnt; pv0 = pv_cnt; d0 = done_cnt; c0 = clash_cnt;

        pulse_edge();
        tick();
        tick();
        @(negedge clk);
        check_eq("err_clr", int'(r_error), 0);
        check_eq("rcving_on", int'(rcving), 1);

        send_byte(s);
        send_byte(p);
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
        for (int k = 0; k < trunc; k++) shift_bit();

        eop = 1'b1;
        shift_bit();
        shift_bit();
        tick();
        eop = 1'b0;
        if (eerr == 0) pulse_edge();
        repeat (4) tick();

        @(negedge clk);
        check_eq("w_enable_cnt", w_cnt - w0, ew);
        check_eq("pid_valid_cnt", pv_cnt - pv0, epv);
        check_eq("rx_done_cnt", done_cnt - d0, ed);
        check_eq("w_done_clash", clash_cnt - c0, 0);
        check_eq("r_error", int'(r_error), eerr);
        check_eq("byte_count", int'(byte_count), ebc);
        check_eq("rx_pid", int'(rx_pid), exp_pid);
        check_eq("rcving_off", int'(rcving), 0);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_rcving"}, int'(rcving), 0);
        check_eq({pfx, "_w_enable"}, int'(w_enable), 0);
        check_eq({pfx, "_r_error"}, int'(r_error), 0);
        check_eq({pfx, "_rx_pid"}, int'(rx_pid), 0);
        check_eq({pfx, "_pid_valid"}, int'(pid_valid), 0);
        check_eq({pfx, "_rx_done"}, int'(rx_done), 0);
        check_eq({pfx, "_byte_count"}, int'(byte_count), 0);
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] p;
        logic [3:0] code;
        int n;
        int trunc;
        int w0;
        int d0;

        n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0; rcv_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        tick();
        n_rst = 1'b1;
        tick();

        // Directed protocol cases
        run_packet(8'h80, 8'hC3, 2, 0);   // good DATA0 packet
        run_packet(8'h81, 8'hC3, 2, 0);   // bad SYNC
        run_packet(8'h80, 8'hC3, 1, 0);   // r_error clears on next packet
        run_packet(8'h80, 8'hC3, 1, 3);   // EOP mid-byte
        run_packet(8'h80, 8'hD2, 67, 0);  // overlong packet
        run_packet(8'h80, 8'hC4, 1, 0);   // PID with bad complement
        run_packet(8'h80, 8'h5A, 0, 0);   // no data bytes

        // Reset in the middle of a data byte
        w0 = w_cnt; d0 = done_cnt;
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'h4B);
        send_byte(8'h11);
        for (int k = 0; k < 3; k++) shift_bit();
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_pid = 0;
        repeat (3) tick();
        n_rst = 1'b1;
        tick();
        check_eq("midrst_w_cnt", w_cnt - w0, 1);
        check_eq("midrst_done_cnt", done_cnt - d0, 0);
        run_packet(8'h80, 8'hE1, 3, 0);

        // Randomized packets
        for (int t = 0; t < 40; t++) begin
            s = 8'h80;
            if ($urandom_range(0, 7) == 0) begin
                s = 8'($urandom);
                if (s == 8'h80) s = 8'h00;
            end
            code = 4'($urandom);
            if ($urandom_range(0, 1) == 0) p = {~code, code};
            else                           p = 8'($urandom);
            n = $urandom_range(0, 5);
            trunc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            run_packet(s, p, n, trunc);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 n_rst  input  1  reset, asynchronous, active-low.
REQ-003 d_edge  input  1  single-cycle pulse on a line transition, from the receiver decoder.
REQ-004 eop  input  1  end-of-packet line state (D+ and D- both low), from the decoder.
REQ-005 shift_enable  input  1  one-cycle strobe at each bit-sample point.
REQ-006 rcv_data  input  8  byte assembled by the shift register; valid in the cycle after byte_done.
REQ-007 rcving  output  1  high while a packet is in progress.
REQ-008 w_enable  output  1  one-cycle strobe that writes rcv_data to the RX FIFO.
REQ-009 r_error  output  1  sticky receive-error flag.
REQ-010 rx_pid  output  4  PID of the current packet.
REQ-011 pid_valid  output  1  one-cycle strobe when rx_pid is loaded.
REQ-012 rx_done  output  1  one-cycle strobe on error-free packet completion.
REQ-013 byte_count  output  7  number of data bytes written in the current packet.

Function
REQ-014 An internal 3-bit bit counter SHALL increment on each shift_enable in the states RECV_SYNC, RECV_PID and RECV_DATA, and SHALL be forced to 0 in all other states.
REQ-015 The bit counter SHALL wrap 7->0 and assert internal byte_done for the cycle following that shift_enable.
REQ-016 The FSM SHALL have these states: IDLE, RECV_SYNC, CHK_SYNC, RECV_PID, CHK_PID, RECV_DATA, WRITE, EOP_WAIT, ERR_EOP, ERR_IDLE.
REQ-017 IDLE: on d_edge, go to RECV_SYNC, clear r_error, and clear byte_count.
REQ-018 RECV_SYNC, RECV_PID, RECV_DATA: on byte_done, go to CHK_SYNC, CHK_PID and WRITE respectively.
REQ-019 CHK_SYNC: if rcv_data==8'h80, go to RECV_PID; otherwise set r_error and go to ERR_EOP.
REQ-020 CHK_PID: load rx_pid=rcv_data[3:0], pulse pid_valid for one cycle, and go to RECV_DATA.
REQ-021 WRITE: pulse w_enable for one cycle, increment byte_count, and return to RECV_DATA.
REQ-022 In WRITE, if byte_count is already 66 (MAX_BYTES), w_enable SHALL NOT assert, r_error SHALL set, and the FSM SHALL go to ERR_EOP.
REQ-023 eop SHALL be evaluated only in a cycle where shift_enable=1.
REQ-024 In RECV_DATA, eop with bit counter 0 SHALL go to EOP_WAIT.
REQ-025 eop with bit counter not 0 in RECV_DATA, or any eop in RECV_SYNC or RECV_PID, SHALL set r_error and go to ERR_IDLE.
REQ-026 If byte_done and a sampled eop coincide, byte_done SHALL take priority.
REQ-027 EOP_WAIT: on d_edge (end of EOP), pulse rx_done and go to IDLE.
REQ-028 ERR_EOP: on a sampled eop, go to ERR_IDLE.
REQ-029 ERR_IDLE: on d_edge, go to RECV_SYNC, clear r_error, and clear byte_count.
REQ-030 rcving SHALL be 1 in every state except IDLE and ERR_IDLE.
REQ-031 Outputs SHALL be registered and have zero combinational paths from inputs.
REQ-032 w_enable and rx_done SHALL never assert in the same cycle.

Reset
REQ-033 On n_rst low: state=IDLE, bit counter=0, rcving=0, w_enable=0, r_error=0, rx_pid=0, pid_valid=0, rx_done=0, byte_count=0.
REQ-034 Reset asserted mid-packet SHALL abort the packet immediately, with no w_enable or rx_done strobe.

Configuration
REQ-035 With USB_RX_PID_CHECK_EN defined, CHK_PID SHALL require rcv_data[7:4]==~rcv_data[3:0]; on mismatch it SHALL set r_error, skip pid_valid and go to ERR_EOP.
REQ-036 Without USB_RX_PID_CHECK_EN, any PID byte SHALL be accepted.

Structure
REQ-037 A shared package usb_rx_pkg SHALL hold the state enum, SYNC_BYTE=8'h80 and MAX_BYTES=7'd66.
REQ-038 The bit counter SHALL be a separate sub-module, rx_bit_counter (clear, count_enable, byte_done).

Verification
REQ-039 Valid packet: SYNC 80, PID 0xC3 (DATA0), 2 data bytes, EOP -> pid_valid with rx_pid=3, two w_enable, byte_count=2, rx_done, rcving=0.
REQ-040 Bad SYNC 0x81 -> r_error=1, no pid_valid, no w_enable; r_error clears on the next packet's d_edge.
REQ-041 EOP after 3 bits of a data byte -> r_error=1, state ERR_IDLE, no rx_done.
REQ-042 Packet of 67 data bytes -> exactly 66 w_enable, r_error=1, then ERR_EOP.
REQ-043 PID 0xC4 with USB_RX_PID_CHECK_EN -> r_error=1; without the macro -> pid_valid with rx_pid=4.
REQ-044 n_rst asserted during RECV_DATA -> all outputs 0 in the same cycle; the next packet is received cleanly.
